// File: rtl/bank_pkg.sv
// Shared types and default geometry for the bank command/data protocol.
package bank_pkg;

  localparam int BANK_NUM_BANKS  = 5;
  localparam int BANK_ADDR_WIDTH = 9;
  localparam int BANK_DATA_WIDTH = 32;

  // One beat across all banks; bank k occupies slice k.
  typedef logic [BANK_NUM_BANKS*BANK_DATA_WIDTH-1:0] bank_data_t;

  // Command as carried on the command channel.
  typedef struct packed {
    logic                       rw;
    logic [BANK_NUM_BANKS-1:0]  mask;
    logic [BANK_ADDR_WIDTH-1:0] addr;
  } bank_cmd_t;

endpackage

// File: rtl/bank_slot_responder_if.sv
// Slot-side command/write/read channels plus the multi-bank RAM port.
interface bank_slot_responder_if
  import bank_pkg::*;
#(
  parameter int NUM_BANKS  = BANK_NUM_BANKS,
  parameter int ADDR_WIDTH = BANK_ADDR_WIDTH,
  parameter int DATA_WIDTH = BANK_DATA_WIDTH
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic                            cmd_rw;
  logic [NUM_BANKS-1:0]            cmd_mask;
  logic [ADDR_WIDTH-1:0]           cmd_addr;
  logic                            wvalid;
  logic                            wready;
  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata;
  logic                            rvalid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata;
  logic [NUM_BANKS-1:0]            ram_en;
  logic                            ram_we;
  logic [ADDR_WIDTH-1:0]           ram_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_wdata;
  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_rdata;
  logic                            busy;

  // Responder view.
  modport slave (
    input  cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata, ram_rdata,
    output cmd_ready, wready, rvalid, rdata, ram_en, ram_we, ram_addr,
           ram_wdata, busy
  );

  // Master slot and RAM view.
  modport master (
    output cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata, ram_rdata,
    input  cmd_ready, wready, rvalid, rdata, ram_en, ram_we, ram_addr,
           ram_wdata, busy
  );

endinterface

// File: rtl/bank_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one wrap bit for full/empty.
module bank_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/bank_slot_responder.sv
// Queues commands and write beats, issues in-order multi-bank RAM accesses
// one per cycle, and returns masked read data after a fixed latency.
module bank_slot_responder
  import bank_pkg::*;
#(
  parameter int NUM_BANKS   = BANK_NUM_BANKS,
  parameter int ADDR_WIDTH  = BANK_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BANK_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int RAM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  bank_slot_responder_if.slave bus
);
  localparam int BEAT_W = NUM_BANKS*DATA_WIDTH;
  localparam int CMD_W  = 1 + NUM_BANKS + ADDR_WIDTH;

  typedef struct packed {
    logic                  rw;
    logic [NUM_BANKS-1:0]  mask;
    logic [ADDR_WIDTH-1:0] addr;
  } cmd_t;

  // Zero every bank slice whose mask bit is clear.
  function automatic logic [BEAT_W-1:0] mask_gate(
    input logic [BEAT_W-1:0]    d,
    input logic [NUM_BANKS-1:0] m
  );
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_BANKS; k++)
      if (m[k]) r[k*DATA_WIDTH +: DATA_WIDTH] = d[k*DATA_WIDTH +: DATA_WIDTH];
    return r;
  endfunction

  logic              ready_en_q;
  logic              cmd_full, cmd_empty, dat_full, dat_empty;
  logic              cmd_push, dat_push;
  cmd_t              cmd_in, cmd_head;
  logic [BEAT_W-1:0] dat_head;
  logic              issue, issue_rd;

  // Return pipeline: the RAM answers RAM_LATENCY cycles after the edge that
  // samples ram_en, so the tag is tracked through RAM_LATENCY+1 stages.
  logic [RAM_LATENCY:0]   rtn_vld_q, rtn_vld_d;
  logic [NUM_BANKS-1:0]   rtn_mask_q [RAM_LATENCY+1];
  logic                   rvalid_q;
  logic [BEAT_W-1:0]      rdata_q;

  // Readies stay low through reset and rise on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  assign bus.cmd_ready = ready_en_q && !cmd_full;
  assign bus.wready    = ready_en_q && !dat_full;
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
  assign dat_push      = bus.wvalid && bus.wready;

  // Pack the incoming command.
  always_comb begin
    cmd_in      = '0;
    cmd_in.rw   = bus.cmd_rw;
    cmd_in.mask = bus.cmd_mask;
    cmd_in.addr = bus.cmd_addr;
  end

  bank_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_push),
    .din_i   (cmd_in),
    .pop_i   (issue),
    .dout_o  (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  bank_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dat_push),
    .din_i   (bus.wdata),
    .pop_i   (issue && cmd_head.rw),
    .dout_o  (dat_head),
    .full_o  (dat_full),
    .empty_o (dat_empty)
  );

  // Issue: head read goes unconditionally, head write waits for its beat.
  always_comb begin
    issue         = 1'b0;
    bus.ram_en    = '0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (!cmd_empty && (!cmd_head.rw || !dat_empty)) begin
      issue         = 1'b1;
      bus.ram_en    = cmd_head.mask;
      bus.ram_we    = cmd_head.rw;
      bus.ram_addr  = cmd_head.addr;
      if (cmd_head.rw) bus.ram_wdata = dat_head;
    end
  end

  assign issue_rd  = issue && !cmd_head.rw;
  assign rtn_vld_d = {rtn_vld_q[RAM_LATENCY-1:0], issue_rd};

  // Return tag valid shift; reset discards reads in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rtn_vld_q <= '0;
    else     rtn_vld_q <= rtn_vld_d;
  end

  // Return mask shift alongside the valid bits.
  always_ff @(posedge clk) begin
    rtn_mask_q[0] <= cmd_head.mask;
    for (int i = 1; i <= RAM_LATENCY; i++) rtn_mask_q[i] <= rtn_mask_q[i-1];
  end

  // Capture gated bank data and pulse rvalid when a tag emerges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rtn_vld_q[RAM_LATENCY];
      if (rtn_vld_q[RAM_LATENCY])
        rdata_q <= mask_gate(bus.ram_rdata, rtn_mask_q[RAM_LATENCY]);
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = !cmd_empty || !dat_empty || (|rtn_vld_q);

endmodule
